// File: rtl/alu_cmd_pkg.sv
// alu_cmd_pkg
// Shared types and widths for the ALU command buffer.
// alu_cmd_t packs one command as {data1, data2, control}, MSB first, which is
// the same packing the ALU bench uses when it scoreboards commands.
package alu_cmd_pkg;

    localparam int OPND_W = 4;
    localparam int CTRL_W = 2;

    typedef struct packed {
        logic [OPND_W-1:0] data1;
        logic [OPND_W-1:0] data2;
        logic [CTRL_W-1:0] control;
    } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_mem.sv
// alu_cmd_mem
// DEPTH-entry command storage with no reset.
// Ports:
//   clk            - clock; writes land on the rising edge
//   we/waddr/wdata - synchronous write port
//   raddr/rdata    - asynchronous read port
module alu_cmd_mem
    import alu_cmd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  alu_cmd_t      wdata,
    input  logic [AW-1:0] raddr,
    output alu_cmd_t      rdata
);

    alu_cmd_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo
// Command FIFO between a producer and the ALU. The oldest command is shown on
// data1/data2/control with valid and is popped when the ALU asserts ready.
// Ports:
//   clk, reset                         - clock, synchronous active-high reset
//   in_data1/in_data2/in_control       - producer command
//   in_valid / in_ready                - producer handshake
//   data1/data2/control/valid/ready    - ALU side handshake, head command
//   count                              - occupancy 0..DEPTH
//   issued                             - commands consumed since reset (wraps)
module alu_cmd_fifo
    import alu_cmd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [OPND_W-1:0]        in_data1,
    input  logic [OPND_W-1:0]        in_data2,
    input  logic [CTRL_W-1:0]        in_control,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [OPND_W-1:0]        data1,
    output logic [OPND_W-1:0]        data2,
    output logic [CTRL_W-1:0]        control,
    output logic                     valid,
    input  logic                     ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         issued
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [CNT_W-1:0] issued_q, issued_d;

    logic     push;
    logic     pop;
    alu_cmd_t wr_cmd;
    alu_cmd_t head_cmd;

    // Both handshakes depend on registered count only, so a full FIFO refuses
    // a push even when the ALU pops on the same edge.
    assign in_ready = (count_q != CW'(DEPTH));
    assign valid    = (count_q != '0);
    assign push     = in_valid && in_ready;
    assign pop      = valid && ready;

    assign wr_cmd = '{data1: in_data1, data2: in_data2, control: in_control};

    alu_cmd_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_cmd),
        .raddr (rd_ptr_q),
        .rdata (head_cmd)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        issued_d = issued_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            issued_d = issued_q + CNT_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            issued_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            issued_q <= issued_d;
        end
    end

    // Storage is not cleared on reset, so the head is masked while empty.
    assign data1   = valid ? head_cmd.data1   : '0;
    assign data2   = valid ? head_cmd.data2   : '0;
    assign control = valid ? head_cmd.control : '0;
    assign count   = count_q;
    assign issued  = issued_q;

endmodule

// File: doc/alu_cmd_fifo.md
# alu_cmd_fifo

Command buffer that sits directly upstream of the ALU. It accepts {data1, data2, control} operation commands from a producer over a valid/ready handshake and stores them in a DEPTH-entry FIFO. It presents the oldest command to the ALU's data1/data2/control/valid inputs and pops it when the ALU asserts ready. This decouples producer bursts from ALU busy periods without dropping or reordering commands.

## Interface
- DEPTH, 8: FIFO entries; power of two, ≥ 2.
- CNT_W, 16: width of the issued-command counter.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data1  input  4  producer operand A.
- in_data2  input  4  producer operand B.
- in_control  input  2  producer ALU opcode.
- in_valid  input  1  producer command valid.
- in_ready  output  1  FIFO can accept a command this cycle.
- data1  output  4  head operand A to ALU.
- data2  output  4  head operand B to ALU.
- control  output  2  head opcode to ALU.
- valid  output  1  head command valid to ALU.
- ready  input  1  ALU ready; a command is consumed on any edge where valid && ready.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- issued  output  CNT_W  number of commands consumed by the ALU since reset; wraps modulo 2^CNT_W.

## Operation
- Push: rising edge with in_valid && in_ready. Writes {in_data1, in_data2, in_control} at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: rising edge with valid && ready. rd_ptr increments modulo DEPTH; issued increments.
- in_ready = (count != DEPTH). It depends only on registered state. No combinational path from ready to in_ready.
- valid = (count != 0).
- data1/data2/control = head entry when valid = 1, and all zeros when valid = 0.
- Once valid is high, the head entry holds stable until it is popped. The FIFO never retracts valid without a pop.
- Simultaneous push and pop (count 1..DEPTH-1): both occur and count is unchanged.
- count = 0: a pop cannot occur. A push gives count = 1.
- count = DEPTH: a push is refused even if a pop occurs on the same edge. The pop still happens and count becomes DEPTH-1.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are derived from count, not from pointer comparison.
- The ordering guarantee is strict FIFO. Commands are never dropped or duplicated.
- in_data* and ready are don't-care while the corresponding valid is low.

## Timing
- Reset, taken on the edge where reset = 1: count = 0, wr_ptr = rd_ptr = 0, issued = 0, valid = 0, in_ready = 1, and data1/data2/control = 0. Storage contents are not cleared.
- Reset mid-operation discards all buffered commands. A push or pop on the reset edge is ignored.
- Push-to-output latency is one cycle. A command pushed into an empty FIFO on edge N appears with valid = 1 after edge N; there is no same-cycle bypass.
- Throughput is one push and one pop per cycle sustained.
- count and issued update on the same edge as the push or pop that changes them.

## Structure
- Shared package alu_cmd_pkg:
  - typedef alu_cmd_t, a packed struct {data1[3:0], data2[3:0], control[1:0]} of 10 bits in that bit order. It matches the {data1,data2,control} packing the ALU bench uses for scoreboarding.
  - Localparams for operand width 4 and opcode width 2.
- One sub-module, alu_cmd_mem: a DEPTH × alu_cmd_t register array with a synchronous write port (we, waddr, wdata) and an asynchronous read port (raddr, rdata). It has no reset.
- Pointers, count, the issued counter and output masking live in alu_cmd_fifo.

## Test plan
- **Reset:** drive reset for 2 cycles with in_valid = 1 → after release, count = 0, valid = 0, in_ready = 1, outputs 0, issued = 0.
- **Fill then drain:** hold ready = 0 and push 8 commands (data1 = i, data2 = 15−i, control = i%4, for i = 0..7).
  - After the 8th push, count = 8 and in_ready = 0. A 9th in_valid is not accepted.
  - Then ready = 1 → the ALU receives all 8 commands in order over 8 cycles, count returns to 0, issued = 8.
- **Simultaneous full push/pop:** at count = 8, drive in_valid = 1 and ready = 1 → pop occurs, push is refused, count = 7. On the next edge the push is accepted and count = 8.
- **Streaming:** drive in_valid = 1 and ready = 1 every cycle for 40 commands from an empty start.
  - Expect count ≤ 1 throughout and valid first high one cycle after the first push.
  - The output sequence must equal the input sequence and issued = 40. This exercises pointer wrap five times.
- **Random backpressure:** connect the ALU with random ready delays and 20 random commands → the scoreboard of {data1,data2,control} captured at valid && ready matches push order exactly, and head outputs stay stable while valid && !ready.
- **Reset mid-burst:** with count = 5, assert reset for one cycle → count = 0 and valid = 0 next cycle. Buffered commands never reach the ALU and issued = 0.
